// File: rtl/gf2089_pkg.sv
// Shared constants and the Barrett quotient estimate for arithmetic over GF(2089).
package gf2089_pkg;
  localparam int Q   = 2089;
  localparam int QW  = 12;
  localparam int K   = 24;
  localparam int M   = 8031;
  localparam int PW  = 2 * QW;   // full product width
  localparam int QEW = 13;       // quotient estimate width, M < 2^13
  localparam int XW  = PW + QEW; // x*M width
  localparam int RW  = QW + 2;   // remainder before correction is < 3Q < 2^14

  typedef logic [QW-1:0]  elem_t;
  typedef logic [PW-1:0]  prod_t;
  typedef logic [QEW-1:0] qe_t;

  localparam elem_t Q_E = elem_t'(Q);

  function automatic qe_t barrett_est(input prod_t x);
    logic [XW-1:0] w_p;
    w_p = XW'(x) * XW'(M);
    return qe_t'(w_p >> K);
  endfunction
endpackage

// File: rtl/modmul_2089_pipe_corr.sv
// Combinational Barrett correction: r = x - qe*Q followed by up to two subtractions of Q.
module barrett_corr_2089
  import gf2089_pkg::*;
(
  input  logic [PW-1:0]  i_x,
  input  logic [QEW-1:0] i_qe,
  output logic [QW-1:0]  o_r
);

  function automatic logic [RW-1:0] sub_q(input logic [RW-1:0] r);
    logic signed [RW:0] d;
    d = $signed({1'b0, r}) - $signed((RW+1)'(Q));
    return d[RW] ? r : RW'(d);
  endfunction

  logic [PW-1:0] w_qq;
  logic [RW-1:0] w_r0;
  logic [RW-1:0] w_r1;
  logic [RW-1:0] w_r2;

  // The true remainder is below 3Q, so keeping only the low RW bits is exact.
  assign w_qq = PW'(i_qe) * PW'(Q);
  assign w_r0 = RW'(i_x - w_qq);
  assign w_r1 = sub_q(w_r0);
  assign w_r2 = sub_q(w_r1);
  assign o_r  = QW'(w_r2);

endmodule

// File: rtl/modmul_2089_pipe.sv
// Three-stage pipelined a*b mod 2089 with valid/ready flow control and a global stall.
module modmul_2089_pipe
  import gf2089_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] in_a,
  input  logic [QW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_r,
  output logic          out_err
);

  logic           w_adv;
  logic           w_err_in;
  logic [PW-1:0]  w_x_in;
  logic [QW-1:0]  w_r;

  logic           r_vld_p0;
  logic           r_err_p0;
  logic [PW-1:0]  r_x_p0;

  logic           r_vld_p1;
  logic           r_err_p1;
  logic [PW-1:0]  r_x_p1;
  logic [QEW-1:0] r_qe_p1;

  logic           r_vld_p2;
  logic           r_err_p2;
  logic [QW-1:0]  r_r_p2;

  // Whole pipeline moves together; a held output freezes every stage.
  assign w_adv    = !r_vld_p2 || out_ready;
  assign in_ready = w_adv;

  assign w_x_in   = PW'(in_a) * PW'(in_b);
  assign w_err_in = (in_a >= Q_E) || (in_b >= Q_E);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_err_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_err_p2 <= 1'b0;
      r_r_p2   <= '0;
    end else if (w_adv) begin
      // S1 -> S2 -> S3 control, plus the registered result
      r_vld_p0 <= in_valid;
      r_err_p0 <= w_err_in;
      r_vld_p1 <= r_vld_p0;
      r_err_p1 <= r_err_p0;
      r_vld_p2 <= r_vld_p1;
      r_err_p2 <= r_err_p1;
      r_r_p2   <= w_r;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      // S1: product; S2: quotient estimate with x carried alongside
      r_x_p0  <= w_x_in;
      r_x_p1  <= r_x_p0;
      r_qe_p1 <= barrett_est(r_x_p0);
    end
  end

  // S3: subtract-and-correct, registered above into r_r_p2
  barrett_corr_2089 u_corr (
    .i_x  (r_x_p1),
    .i_qe (r_qe_p1),
    .o_r  (w_r)
  );

  assign out_valid = r_vld_p2;
  assign out_r     = r_r_p2;
  assign out_err   = r_err_p2;

endmodule
